// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the responder state encoding.
package apb_pkg;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;
  localparam int unsigned APB_SW = 4;

  typedef enum logic [0:0] {
    IDLE,
    ACCESS
  } apb_resp_state_t;

endpackage

// File: rtl/apb_mem_responder_if.sv
// APB bus bundle between the bridge (master) and the memory responder (slave).
interface apb_mem_responder_if;
  import apb_pkg::*;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [APB_AW-1:0] paddr;
  logic [APB_DW-1:0] pwdata;
  logic [APB_SW-1:0] pstrb;
  logic [APB_DW-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/bytemem.sv
// Byte-enable word RAM with a registered, clearable read port.
module bytemem #(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          re,
  input  logic          clr,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // clr wins so the read port can be forced to zero on completion or error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (clr) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apb_mem_responder.sv
// APB memory responder: captures the setup phase, waits WAIT_STATES cycles, then completes.
module apb_mem_responder
  import apb_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter int unsigned       WAIT_STATES = 1,
  parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  apb_mem_responder_if.slave  bus
);

  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  apb_resp_state_t   state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic              write_q, err_q;
  logic [IW-1:0]     idx_q;
  logic [APB_DW-1:0] wdata_q;
  logic [APB_SW-1:0] strb_q;

  logic [APB_AW-1:0] offset;
  logic              err_now;
  logic [IW-1:0]     idx_now;
  logic              setup;
  logic              mem_we, mem_re, mem_clr;

  assign offset  = bus.paddr - BASE_ADDR;
  assign err_now = (bus.paddr[1:0] != 2'b00) || (offset >= APB_AW'(DEPTH_WORDS * 4));
  assign idx_now = offset[IW+1:2];
  assign setup   = (state_q == IDLE) && bus.psel && !bus.penable;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
          // Zero-wait: the setup edge is also the edge that raises pready.
          if (WAIT_STATES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = err_now;
            mem_re    = !bus.pwrite && !err_now;
            mem_clr   = err_now;
          end
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          mem_clr   = 1'b1;
        end else if (pready_q) begin
          if (bus.penable) begin
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            mem_clr   = 1'b1;
            mem_we    = write_q && !err_q;
          end
        end else if (cnt_q <= 4'd1) begin
          pready_d  = 1'b1;
          pslverr_d = err_q;
          mem_re    = !write_q && !err_q;
          mem_clr   = err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (setup) begin
      write_q <= bus.pwrite;
      err_q   <= err_now;
      idx_q   <= idx_now;
      wdata_q <= bus.pwdata;
      strb_q  <= bus.pstrb;
    end
  end

  bytemem #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .re    (mem_re),
    .clr   (mem_clr),
    .raddr ((state_q == IDLE) ? idx_now : idx_q),
    .rdata (bus.prdata)
  );

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule
